// File: rtl/bc6502_bus_pkg.sv
// Shared types and constants for the bc6502 external memory bus.
package bc6502_bus_pkg;

  // Who owns the current bus slot.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Address bit that splits RAM (low half) from ROM (high half).
  localparam int RAM_SEL_BIT = 15;

endpackage

// File: rtl/bc6502_bus_arbiter.sv
// Slot-by-slot arbiter between the bc6502 CPU and a single DMA requester.
// DMA only steals CPU read slots (the CPU is held with rdy); after DMA_MAX
// back-to-back DMA slots one CPU slot is forced before the next grant.
module bc6502_bus_arbiter
  import bc6502_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int DMA_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ma,
  input  logic          cpu_rw,
  input  logic [DW-1:0] cpu_do,
  output logic [DW-1:0] cpu_di,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_rw,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_rw,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          ram_ce_n,
  output logic          rom_ce_n
);

  // Four bits cover the whole 1..15 range of DMA_MAX.
  localparam int            CW    = 4;
  localparam logic [CW-1:0] MAX_C = CW'(DMA_MAX);

  owner_e        owner;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] burst_next;
  logic          grant;

  logic [AW-1:0] lat_addr;
  logic          lat_rw;
  logic [DW-1:0] lat_wdata;

  // Burst count as it stands after the current slot, and the grant decision for the next slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    burst_next = '0;
    if (owner == OWN_DMA) begin
      burst_next = (burst_cnt < MAX_C) ? burst_cnt + CW'(1) : burst_cnt;
    end
    // A CPU slot clears the count, so a pending request is granted right after the forced slot.
    grant = dma_req && (cpu_rw == RW_READ) && (burst_next < MAX_C);
  end

  // Owner FSM with registered rdy/ack, burst counter and DMA capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: only control and capture registers are reset; the memories are outside this block.
      owner     <= OWN_CPU;
      burst_cnt <= '0;
      cpu_rdy   <= 1'b1;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      lat_addr  <= '0;
      lat_rw    <= RW_READ;
      lat_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      burst_cnt <= burst_next;
      if (owner == OWN_DMA && lat_rw == RW_READ) begin
        dma_rdata <= mem_rdata;
      end
      if (grant) begin
        owner     <= OWN_DMA;
        cpu_rdy   <= 1'b0;
        dma_ack   <= 1'b1;
        lat_addr  <= dma_addr;
        lat_rw    <= dma_rw;
        lat_wdata <= dma_wdata;
      end else begin
        owner   <= OWN_CPU;
        cpu_rdy <= 1'b1;
        dma_ack <= 1'b0;
      end
    end
  end

  // Bus mux follows the slot owner; reset parks the bus in read so no write can slip out.
  assign mem_a     = (owner == OWN_DMA) ? lat_addr  : cpu_ma;
  assign mem_wdata = (owner == OWN_DMA) ? lat_wdata : cpu_do;
  assign mem_rw    = reset ? RW_READ : ((owner == OWN_DMA) ? lat_rw : cpu_rw);

  assign cpu_di = (owner == OWN_CPU && cpu_rw == RW_READ) ? mem_rdata : '0;

  assign ram_ce_n = mem_a[RAM_SEL_BIT];
  assign rom_ce_n = ~mem_a[RAM_SEL_BIT];

endmodule

// File: tb/tb_bc6502_bus_arbiter.sv
// Self-checking bench for bc6502_bus_arbiter: directed table, hand-written
// corner sequences and a randomized run against a slot-level reference model.
module tb_bc6502_bus_arbiter;

  localparam int DMA_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ma;
  logic        cpu_rw;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_a;
  logic        mem_rw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        ram_ce_n;
  logic        rom_ce_n;

  always #5 clk = ~clk;

  bc6502_bus_arbiter #(.AW(16), .DW(8), .DMA_MAX(DMA_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_ma    (cpu_ma),
    .cpu_rw    (cpu_rw),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .cpu_rdy   (cpu_rdy),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_rw    (dma_rw),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_a     (mem_a),
    .mem_rw    (mem_rw),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ram_ce_n  (ram_ce_n),
    .rom_ce_n  (rom_ce_n)
  );

  // ---------------- memory chips ----------------
  logic [7:0] ram [0:32767];
  logic [7:0] rom [0:8191];
  logic       ram_init;

  function automatic logic [7:0] ram_init_val(input int i);
    if (i == 16'h0010) return 8'hA5;
    return 8'(i * 7 + 19);
  endfunction

  assign mem_rdata = mem_a[15] ? rom[mem_a[12:0]] : ram[mem_a[14:0]];

  // Synchronous RAM: preload during bench start-up, then write on enabled write slots.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init_val(i);
    end else if (!ram_ce_n && !mem_rw) begin
      ram[mem_a[14:0]] <= mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  // Slot-level view: which party owns this slot, how many DMA slots in a row
  // have run, what the granted request was, and what the requester last read.
  logic [7:0]  ref_ram [0:32767];
  logic        m_dma;
  int          m_run;
  logic [15:0] m_addr;
  logic        m_rw;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return a[15] ? rom[a[12:0]] : ref_ram[a[14:0]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dma   = 1'b0;
    m_run   = 0;
    m_addr  = '0;
    m_rw    = 1'b1;
    m_wdata = '0;
    m_rdata = '0;
  endtask

  // Compare every output with what the model says the current slot looks like.
  task automatic model_compare();
    logic [15:0] ea;
    logic        ew;
    logic [7:0]  ed;
    logic [7:0]  edi;
    if (m_dma) begin
      ea = m_addr; ew = m_rw; ed = m_wdata; edi = 8'h00;
    end else begin
      ea = cpu_ma; ew = cpu_rw; ed = cpu_do;
      edi = cpu_rw ? ref_read(cpu_ma) : 8'h00;
    end
    check("cpu_rdy",   32'(cpu_rdy),   32'(!m_dma));
    check("dma_ack",   32'(dma_ack),   32'(m_dma));
    check("mem_a",     32'(mem_a),     32'(ea));
    check("mem_rw",    32'(mem_rw),    32'(ew));
    check("mem_wdata", 32'(mem_wdata), 32'(ed));
    check("cpu_di",    32'(cpu_di),    32'(edi));
    check("dma_rdata", 32'(dma_rdata), 32'(m_rdata));
    check("ram_ce_n",  32'(ram_ce_n),  32'(ea[15]));
    check("rom_ce_n",  32'(rom_ce_n),  32'(!ea[15]));
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (m_dma) begin
      if (m_rw) m_rdata = ref_read(m_addr);
      else if (!m_addr[15]) ref_ram[m_addr[14:0]] = m_wdata;
      m_run++;
    end else begin
      if (!cpu_rw && !cpu_ma[15]) ref_ram[cpu_ma[14:0]] = cpu_do;
      m_run = 0;
    end
    if (dma_req && cpu_rw && m_run < DMA_MAX) begin
      m_dma   = 1'b1;
      m_addr  = dma_addr;
      m_rw    = dma_rw;
      m_wdata = dma_wdata;
    end else begin
      m_dma = 1'b0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_compare();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic req, input logic rw, input logic [15:0] ma, input logic [7:0] dout,
                       input logic [15:0] da, input logic dr, input logic [7:0] dw);
    dma_req = req; cpu_rw = rw; cpu_ma = ma; cpu_do = dout;
    dma_addr = da; dma_rw = dr; dma_wdata = dw;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic req;
    logic rw;
    logic exp_ack;
    logic exp_rdy;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // CPU writes hold off the grant, then a held request shows the burst limit.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 8192; i++) rom[i] = 8'(i ^ (i >> 5));
    rom[13'h1FFC] = 8'hE2;
    for (int i = 0; i < 32768; i++) ref_ram[i] = (i < 256) ? ram_init_val(i) : 8'h00;
    model_reset();

    // ---- reset state; a CPU write during reset must not reach the RAM ----
    reset = 1'b1;
    ram_init = 1'b1;
    drive(1'b0, 1'b0, 16'h0040, 8'hEE, 16'h0000, 1'b1, 8'h00);
    @(posedge clk); #1;
    ram_init = 1'b0;
    @(negedge clk);
    check("rst_rdy",    32'(cpu_rdy),   32'd1);
    check("rst_ack",    32'(dma_ack),   32'd0);
    check("rst_rdata",  32'(dma_rdata), 32'd0);
    check("rst_mem_rw", 32'(mem_rw),    32'd1);
    @(posedge clk); #1;
    check("rst_no_write", 32'(ram[16'h0040]), 32'(ram_init_val(16'h0040)));
    cpu_rw = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // ---- CPU reset-vector fetch from ROM ----
    drive(1'b0, 1'b1, 16'hFFFC, 8'h00, 16'h0000, 1'b1, 8'h00);
    at_neg();
    check("fetch_rom_ce_n", 32'(rom_ce_n), 32'd0);
    check("fetch_ram_ce_n", 32'(ram_ce_n), 32'd1);
    check("fetch_cpu_di",   32'(cpu_di),   32'h00E2);
    at_pos();

    // ---- DMA read of RAM[0x0010] during a CPU read ----
    drive(1'b1, 1'b1, 16'h0200, 8'h00, 16'h0010, 1'b1, 8'h00);
    at_neg();
    check("rd_pre_ack", 32'(dma_ack), 32'd0);
    at_pos();
    dma_req = 1'b0;
    at_neg();
    check("rd_ack",   32'(dma_ack), 32'd1);
    check("rd_stall", 32'(cpu_rdy), 32'd0);
    check("rd_mem_a", 32'(mem_a),   32'h0010);
    at_pos();
    at_neg();
    check("rd_ack_off",  32'(dma_ack),   32'd0);
    check("rd_resume",   32'(cpu_rdy),   32'd1);
    check("rd_rdata",    32'(dma_rdata), 32'h00A5);
    check("rd_same_ma",  32'(mem_a),     32'h0200);
    at_pos();

    // ---- table: writes are never stolen, then burst limit with held request ----
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].rw, 16'h0020, 8'h3C, 16'h0030, 1'b1, 8'h00);
      at_neg();
      check($sformatf("tbl%0d_ack", i), 32'(dma_ack), 32'(vecs[i].exp_ack));
      check($sformatf("tbl%0d_rdy", i), 32'(cpu_rdy), 32'(vecs[i].exp_rdy));
      at_pos();
    end
    check("cpu_wr_ram20", 32'(ram[16'h0020]), 32'h003C);

    // ---- DMA write of 0x5A to 0x0040 ----
    drive(1'b1, 1'b1, 16'h0300, 8'h00, 16'h0040, 1'b0, 8'h5A);
    at_neg();
    check("wr_pre_rw", 32'(mem_rw), 32'd1);
    at_pos();
    dma_req = 1'b0;
    at_neg();
    check("wr_rw",     32'(mem_rw),    32'd0);
    check("wr_ce",     32'(ram_ce_n),  32'd0);
    check("wr_wdata",  32'(mem_wdata), 32'h005A);
    check("wr_cpu_di", 32'(cpu_di),    32'h0000);
    at_pos();
    at_neg();
    check("wr_post_rw", 32'(mem_rw),        32'd1);
    check("wr_ram40",   32'(ram[16'h0040]), 32'h005A);
    at_pos();

    // ---- reset in the middle of a DMA write slot ----
    drive(1'b1, 1'b1, 16'h0300, 8'h00, 16'h0050, 1'b0, 8'h99);
    at_neg();
    at_pos();
    dma_req = 1'b0;
    at_neg();
    check("mid_ack_before", 32'(dma_ack), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_ack",    32'(dma_ack),   32'd0);
    check("mid_rdy",    32'(cpu_rdy),   32'd1);
    check("mid_mem_rw", 32'(mem_rw),    32'd1);
    check("mid_rdata",  32'(dma_rdata), 32'd0);
    @(posedge clk); #1;
    check("mid_ram50", 32'(ram[16'h0050]), 32'(ram_init_val(16'h0050)));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 600; c++) begin
      logic [7:0] r8;
      r8 = 8'($urandom);
      if (!m_dma) begin
        cpu_rw = ($urandom_range(0, 3) != 0);
        cpu_ma = ($urandom_range(0, 3) == 0) ? {8'hFF, r8} : {8'h00, r8};
        cpu_do = 8'($urandom);
      end
      dma_req   = ($urandom_range(0, 2) != 0);
      dma_addr  = ($urandom_range(0, 3) == 0) ? {8'hFF, 8'($urandom)} : {8'h00, 8'($urandom)};
      dma_rw    = 1'($urandom);
      dma_wdata = 8'($urandom);
      at_neg();
      at_pos();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
